// File: rtl/mover_3d_agen.sv
// 3D strided burst-command generator: walks width x height x channel and emits AXI bursts.
// Define MOVER_AGEN_SPLIT_4K_EN to also split bursts so none crosses a 4KB address boundary.
module mover_3d_agen #(
    parameter int AXI_WIDTH_AD = 32,
    parameter int AXI_WIDTH_DA = 32,
    parameter int DIM_WIDTH    = 16,
    parameter int MAX_BURST    = 256
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [AXI_WIDTH_AD-1:0] cmd_base,
    input  logic [DIM_WIDTH-1:0]    cmd_width,
    input  logic [DIM_WIDTH-1:0]    cmd_height,
    input  logic [DIM_WIDTH-1:0]    cmd_channel,
    input  logic [AXI_WIDTH_AD-1:0] cmd_row_stride,
    input  logic [AXI_WIDTH_AD-1:0] cmd_plane_stride,
    output logic                    brst_valid,
    input  logic                    brst_ready,
    output logic [AXI_WIDTH_AD-1:0] brst_addr,
    output logic [7:0]              brst_len,
    output logic                    brst_last,
    output logic                    busy,
    output logic                    done
);

    localparam int BPI       = AXI_WIDTH_DA / 8;
    localparam int BPI_SHIFT = $clog2(BPI);
    localparam int CW        = (DIM_WIDTH > 13) ? DIM_WIDTH : 13;
    localparam logic [CW-1:0] MAX_BEATS = CW'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE,
        GEN,
        DONE
    } state_t;

    state_t                  state_q;
    logic                    cmdReady_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    brstValid_q;
    logic                    brstLast_q;
    logic [7:0]              brstLen_q;
    logic [AXI_WIDTH_AD-1:0] curAddr_q;
    logic [AXI_WIDTH_AD-1:0] rowAddr_q;
    logic [AXI_WIDTH_AD-1:0] planeAddr_q;
    logic [DIM_WIDTH-1:0]    rowRem_q;
    logic [DIM_WIDTH-1:0]    rowCnt_q;
    logic [DIM_WIDTH-1:0]    planeCnt_q;
    logic [DIM_WIDTH-1:0]    width_q;
    logic [DIM_WIDTH-1:0]    height_q;
    logic [DIM_WIDTH-1:0]    channel_q;
    logic [AXI_WIDTH_AD-1:0] rowStride_q;
    logic [AXI_WIDTH_AD-1:0] planeStride_q;

    logic [AXI_WIDTH_AD-1:0] curAddr_d;
    logic [AXI_WIDTH_AD-1:0] rowAddr_d;
    logic [AXI_WIDTH_AD-1:0] planeAddr_d;
    logic [DIM_WIDTH-1:0]    rowRem_d;
    logic [DIM_WIDTH-1:0]    rowCnt_d;
    logic [DIM_WIDTH-1:0]    planeCnt_d;
    logic [DIM_WIDTH-1:0]    heightSel;
    logic [DIM_WIDTH-1:0]    channelSel;
    logic [CW-1:0]           curBeats;
    logic [CW-1:0]           beats_d;
    logic [7:0]              brstLen_d;
    logic                    brstLast_d;
    logic                    zeroDim;
`ifdef MOVER_AGEN_SPLIT_4K_EN
    logic [12:0]             toBoundary;
    logic [CW-1:0]           boundBeats;
`endif

    assign cmd_ready  = cmdReady_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign brst_valid = brstValid_q;
    assign brst_last  = brstLast_q;
    assign brst_len   = brstLen_q;
    assign brst_addr  = curAddr_q;
    assign zeroDim    = (cmd_width == '0) || (cmd_height == '0) || (cmd_channel == '0);

    // Position of the burst to present next: the descriptor start while idle, else the step past the current burst.
    always_comb begin
        curAddr_d   = curAddr_q;
        rowAddr_d   = rowAddr_q;
        planeAddr_d = planeAddr_q;
        rowRem_d    = rowRem_q;
        rowCnt_d    = rowCnt_q;
        planeCnt_d  = planeCnt_q;
        heightSel   = height_q;
        channelSel  = channel_q;
        curBeats    = CW'(brstLen_q) + CW'(1);

        if (state_q == IDLE) begin
            curAddr_d   = cmd_base;
            rowAddr_d   = cmd_base;
            planeAddr_d = cmd_base;
            rowRem_d    = cmd_width;
            rowCnt_d    = '0;
            planeCnt_d  = '0;
            heightSel   = cmd_height;
            channelSel  = cmd_channel;
        end else if (CW'(rowRem_q) != curBeats) begin
            curAddr_d = curAddr_q + (AXI_WIDTH_AD'(curBeats) << BPI_SHIFT);
            rowRem_d  = rowRem_q - DIM_WIDTH'(curBeats);
        end else if (rowCnt_q != (height_q - DIM_WIDTH'(1))) begin
            rowAddr_d = rowAddr_q + rowStride_q;
            curAddr_d = rowAddr_q + rowStride_q;
            rowCnt_d  = rowCnt_q + DIM_WIDTH'(1);
            rowRem_d  = width_q;
        end else begin
            planeAddr_d = planeAddr_q + planeStride_q;
            rowAddr_d   = planeAddr_q + planeStride_q;
            curAddr_d   = planeAddr_q + planeStride_q;
            rowCnt_d    = '0;
            planeCnt_d  = planeCnt_q + DIM_WIDTH'(1);
            rowRem_d    = width_q;
        end

        beats_d = CW'(rowRem_d);
        if (beats_d > MAX_BEATS) begin
            beats_d = MAX_BEATS;
        end
`ifdef MOVER_AGEN_SPLIT_4K_EN
        toBoundary = 13'h1000 - {1'b0, curAddr_d[11:0]};
        boundBeats = CW'(toBoundary >> BPI_SHIFT);
        if (beats_d > boundBeats) begin
            beats_d = boundBeats;
        end
`endif
        brstLen_d  = 8'(beats_d - CW'(1));
        brstLast_d = (beats_d == CW'(rowRem_d)) &&
                     (rowCnt_d == (heightSel - DIM_WIDTH'(1))) &&
                     (planeCnt_d == (channelSel - DIM_WIDTH'(1)));
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q       <= IDLE;
            cmdReady_q    <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            brstValid_q   <= 1'b0;
            brstLast_q    <= 1'b0;
            brstLen_q     <= '0;
            curAddr_q     <= '0;
            rowAddr_q     <= '0;
            planeAddr_q   <= '0;
            rowRem_q      <= '0;
            rowCnt_q      <= '0;
            planeCnt_q    <= '0;
            width_q       <= '0;
            height_q      <= '0;
            channel_q     <= '0;
            rowStride_q   <= '0;
            planeStride_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (cmd_valid) begin
                        width_q       <= cmd_width;
                        height_q      <= cmd_height;
                        channel_q     <= cmd_channel;
                        rowStride_q   <= cmd_row_stride;
                        planeStride_q <= cmd_plane_stride;
                        curAddr_q     <= curAddr_d;
                        rowAddr_q     <= rowAddr_d;
                        planeAddr_q   <= planeAddr_d;
                        rowRem_q      <= rowRem_d;
                        rowCnt_q      <= rowCnt_d;
                        planeCnt_q    <= planeCnt_d;
                        cmdReady_q    <= 1'b0;
                        busy_q        <= 1'b1;
                        if (zeroDim) begin
                            state_q    <= DONE;
                            done_q     <= 1'b1;
                            brstLast_q <= 1'b0;
                            brstLen_q  <= '0;
                        end else begin
                            state_q     <= GEN;
                            brstValid_q <= 1'b1;
                            brstLen_q   <= brstLen_d;
                            brstLast_q  <= brstLast_d;
                        end
                    end
                end
                GEN: begin
                    if (brst_ready) begin
                        if (brstLast_q) begin
                            state_q     <= DONE;
                            brstValid_q <= 1'b0;
                            brstLast_q  <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            curAddr_q   <= curAddr_d;
                            rowAddr_q   <= rowAddr_d;
                            planeAddr_q <= planeAddr_d;
                            rowRem_q    <= rowRem_d;
                            rowCnt_q    <= rowCnt_d;
                            planeCnt_q  <= planeCnt_d;
                            brstLen_q   <= brstLen_d;
                            brstLast_q  <= brstLast_d;
                        end
                    end
                end
                DONE: begin
                    state_q    <= IDLE;
                    done_q     <= 1'b0;
                    cmdReady_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
